// File: rtl/alu_share_ctrl_if.sv
// Bundle between the two clients, the shared ALU and the response consumer.
// Latency: none, wires only.
// Backpressure: carried by rsp_valid/rsp_ready; requests stay pending until ack.
//
// Ports:
//   master : client/ALU/consumer side (drives requests, ALU result, rsp_ready)
//   slave  : scheduler side (drives acks, ALU operands, response)
interface alu_share_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic             ack0;
  logic             ack1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_status;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_ready;

  modport master (
    output req0, req1, a0, b0, a1, b1, op0, op1, alu_result, rsp_ready,
    input  ack0, ack1, alu_a, alu_b, alu_status, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, op0, op1, alu_result, rsp_ready,
    output ack0, ack1, alu_a, alu_b, alu_status, rsp_valid, rsp_id, rsp_result
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Two-client scheduler for one shared clocked ALU, returns id-tagged results.
// Latency: ack at T, operands on ALU at T+1, rsp_valid at T+ALU_LAT+2.
// Backpressure: response held until rsp_ready; no new grant until it completes.
//
// Ports: clk, rst (synchronous, active-high); bus (alu_share_ctrl_if.slave):
//   req/a/b/op per client in, ack per client out, alu_a/alu_b/alu_status out,
//   alu_result in, rsp_valid/rsp_id/rsp_result out, rsp_ready in.
// Option: define ALU_SHARE_FIXED_PRIO_EN for fixed priority (client 0 wins);
//   default build is round-robin.
module alu_share_ctrl #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  // Counter must hold ALU_LAT+1.
  localparam int CW = (ALU_LAT + 2 > 2) ? $clog2(ALU_LAT + 2) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          grant_vld;
  logic          grant_id;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  // Id of the client most recently served; reset value 1 lets client 0 win
  // the first tie.
  logic          last_id;
`endif

  // Grant decision is combinational so ack lands in the same IDLE cycle.
  // Reset gates it so ack never pulses while rst is asserted.
  always_comb begin
    grant_vld = (state == IDLE) && !rst && (bus.req0 || bus.req1);
`ifdef ALU_SHARE_FIXED_PRIO_EN
    grant_id  = !bus.req0;
`else
    if (bus.req0 && bus.req1)
      grant_id = ~last_id;
    else
      grant_id = bus.req1;
`endif
  end

  assign bus.ack0 = grant_vld && !grant_id;
  assign bus.ack1 = grant_vld &&  grant_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_status <= 2'b00;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_id        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            bus.alu_a      <= grant_id ? bus.a1  : bus.a0;
            bus.alu_b      <= grant_id ? bus.b1  : bus.b0;
            bus.alu_status <= grant_id ? bus.op1 : bus.op0;
            bus.rsp_id     <= grant_id;
            cnt            <= CW'(ALU_LAT + 1);
            state          <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          // Last WAIT cycle: the ALU output now reflects our operands.
          if (cnt == CW'(1)) begin
            bus.rsp_result <= bus.alu_result;
            bus.rsp_valid  <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            // Pointer moves only when the response is delivered.
            last_id       <= bus.rsp_id;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed cases from the plan then random traffic.
// A driver pushes expected responses on each ack; a negedge monitor checks
// arbitration, timing, operands and responses against a reference model.
module tb_alu_share_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_share_ctrl_if #(.WIDTH(W)) bus ();

  alu_share_ctrl #(.WIDTH(W), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference arithmetic: plain integer math folded modulo 16.
  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] op);
    int r;
    case (op)
      2'b00:   r = int'(a) + int'(b);
      2'b01:   r = int'(a) - int'(b);
      2'b10:   r = int'(a & b);
      default: r = int'(a | b);
    endcase
    r = (r + 16) % 16;
    return r[3:0];
  endfunction

  // External ALU with one clock of latency.
  always @(posedge clk) bus.alu_result <= ref_alu(bus.alu_a, bus.alu_b, bus.alu_status);

  typedef struct {
    logic       id;
    logic [3:0] res;
  } exp_t;
  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic id, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op);
    exp_t e;
    e.id  = id;
    e.res = ref_alu(a, b, op);
    sb.push_back(e);
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         grant_cyc = 0;
  logic       busy = 1'b0;
  logic       last_served = 1'b1;
  logic       prev_rst = 1'b0;
  logic       rsp_seen = 1'b0;
  logic [3:0] ga = '0, gb = '0;
  logic [1:0] gop = '0;

  always @(negedge clk) begin
    logic busy_q;
    logic exp_w;
    cyc++;
    busy_q = busy;
    if (rst) begin
      chk("ack_in_rst", {bus.ack0, bus.ack1}, 0);
      sb.delete();
      busy        = 1'b0;
      last_served = 1'b1;
      rsp_seen    = 1'b0;
    end else begin
      if (prev_rst)
        chk("reset_vals", {bus.rsp_valid, bus.rsp_id, bus.rsp_result,
                           bus.alu_a, bus.alu_b, bus.alu_status}, 0);
      if (busy_q)
        chk("alu_operands", {bus.alu_a, bus.alu_b, bus.alu_status}, {ga, gb, gop});
      if (!busy_q && (bus.req0 || bus.req1))
        chk("idle_grant", bus.ack0 | bus.ack1, 1);
      if (bus.ack0 || bus.ack1) begin
        chk("ack_onehot", bus.ack0 & bus.ack1, 0);
        chk("ack_while_busy", busy_q, 0);
        chk("ack_has_req", bus.ack1 ? bus.req1 : bus.req0, 1);
`ifdef ALU_SHARE_FIXED_PRIO_EN
        exp_w = bus.req0 ? 1'b0 : 1'b1;
`else
        if (bus.req0 && bus.req1) exp_w = (last_served == 1'b0) ? 1'b1 : 1'b0;
        else                      exp_w = bus.req1 ? 1'b1 : 1'b0;
`endif
        chk("winner", bus.ack1, exp_w);
        busy      = 1'b1;
        grant_cyc = cyc;
        rsp_seen  = 1'b0;
        ga        = bus.ack1 ? bus.a1  : bus.a0;
        gb        = bus.ack1 ? bus.b1  : bus.b0;
        gop       = bus.ack1 ? bus.op1 : bus.op0;
      end
      if (bus.rsp_valid) begin
        chk("rsp_while_idle", busy_q, 1);
        if (!rsp_seen) begin
          chk("rsp_latency", cyc - grant_cyc, 3);
          rsp_seen = 1'b1;
        end
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          chk("rsp_id", bus.rsp_id, sb[0].id);
          chk("rsp_result", bus.rsp_result, sb[0].res);
        end
        if (bus.rsp_ready) begin
          if (sb.size() != 0) begin
            last_served = sb[0].id;
            void'(sb.pop_front());
          end
          busy = 1'b0;
        end
      end else if (busy_q) begin
        chk("rsp_not_late", (cyc - grant_cyc) < 3, 1);
      end
    end
    prev_rst = rst;
  end

  // ---------------- driver ----------------
  task automatic issue(input logic r0, input logic [3:0] x0, input logic [3:0] y0,
                       input logic [1:0] o0, input logic r1, input logic [3:0] x1,
                       input logic [3:0] y1, input logic [1:0] o1, input int stall);
    logic p0, p1;
    int   budget;
    int   st;
    p0 = r0;
    p1 = r1;
    st = stall;
    budget = 0;
    @(posedge clk); #1;
    bus.req0 = r0; bus.a0 = x0; bus.b0 = y0; bus.op0 = o0;
    bus.req1 = r1; bus.a1 = x1; bus.b1 = y1; bus.op1 = o1;
    bus.rsp_ready = (st == 0);
    while ((p0 || p1 || sb.size() != 0) && budget < 60) begin
      @(negedge clk);
      if (bus.ack0) begin p0 = 1'b0; push(1'b0, x0, y0, o0); end
      if (bus.ack1) begin p1 = 1'b0; push(1'b1, x1, y1, o1); end
      if (bus.rsp_valid && st > 0) st--;
      @(posedge clk); #1;
      if (!p0) bus.req0 = 1'b0;
      if (!p1) bus.req1 = 1'b0;
      bus.rsp_ready = (st == 0);
      budget++;
    end
    chk("directed_done", budget < 60, 1);
  endtask

  initial begin
    logic g0, g1;
    int   budget;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.op0 = '0;
    bus.a1 = '0; bus.b1 = '0; bus.op1 = '0;
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    issue(1'b1, 4'b0100, 4'b0011, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 0);
    issue(1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 4'b0010, 4'b0101, 2'b01, 0);
    issue(1'b1, 4'b1000, 4'b0111, 2'b10, 1'b1, 4'b1111, 4'b1001, 2'b11, 0);
    issue(1'b1, 4'b1000, 4'b0111, 2'b10, 1'b1, 4'b1111, 4'b1001, 2'b11, 0);
    issue(1'b1, 4'h9, 4'h9, 2'b00, 1'b1, 4'h3, 4'h1, 2'b01, 4);

    // Reset one cycle after a grant: that operation must vanish.
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.a0 = 4'hA; bus.b0 = 4'h3; bus.op0 = 2'b01;
    budget = 0;
    g0 = 1'b0;
    while (!g0 && budget < 10) begin
      @(negedge clk);
      g0 = bus.ack0;
      if (g0) push(1'b0, bus.a0, bus.b0, bus.op0);
      @(posedge clk); #1;
      budget++;
    end
    chk("rst_test_ack", g0, 1);
    bus.req0 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    issue(1'b1, 4'h5, 4'h6, 2'b00, 1'b0, 4'h0, 4'h0, 2'b00, 0);

    // Random traffic with occasional mid-flight resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      g0 = bus.ack0;
      g1 = bus.ack1;
      if (g0) push(1'b0, bus.a0, bus.b0, bus.op0);
      if (g1) push(1'b1, bus.a1, bus.b1, bus.op1);
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
      end else if ((g0 || g1) && $urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end else begin
        if (!bus.req0 || g0) begin
          bus.req0 = ($urandom_range(0, 2) != 0);
          bus.a0 = 4'($urandom); bus.b0 = 4'($urandom); bus.op0 = 2'($urandom);
        end
        if (!bus.req1 || g1) begin
          bus.req1 = ($urandom_range(0, 2) != 0);
          bus.a1 = 4'($urandom); bus.b1 = 4'($urandom); bus.op1 = 2'($urandom);
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain: stop requesting, accept everything outstanding.
    @(negedge clk);
    if (bus.ack0) push(1'b0, bus.a0, bus.b0, bus.op0);
    if (bus.ack1) push(1'b1, bus.a1, bus.b1, bus.op1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.rsp_ready = 1'b1;
    budget = 0;
    while (sb.size() != 0 && budget < 30) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    chk("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
